sd_sector_scheduler: RTL and testbench
======================================

SD_SECTOR_SCHEDULER -- requirements
Module: sd_sector_scheduler

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 2: SD_InputAddress increment per sector (SD argument units of 256 bytes).
REQ-002 SHALL have parameter SECTOR_BYTES, default 512: bytes captured per sector and per bank.
REQ-003 SHALL have port MasterCLK  in  1: single clock for all logic.
REQ-004 SHALL have port Reset  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port Start  in  1: one-cycle pulse that latches StartAddress and SectorCount.
REQ-006 SHALL have port StartAddress  in  24: first sector address.
REQ-007 SHALL have port SectorCount  in  16: sectors to stream; 0 means none.
REQ-008 SHALL have ports SD_InputData  in  8, SD_EnableDataRead  in  1 and SD_InputDataClock  in  1: byte stream from the SD SPI reader, asynchronous to MasterCLK.
REQ-009 SHALL have port SD_InputAddress  out  24: sector address presented to the SD SPI reader.
REQ-010 SHALL have ports RdReq  in  1, RdData  out  8 and RdValid  out  1: consumer pop interface.
REQ-011 SHALL have ports Busy  out  1, Done  out  1, Overrun  out  1 and Underrun  out  1: status flags.

Function
REQ-012 SHALL pass SD_InputDataClock and SD_EnableDataRead through 2-FF synchronizers, and SHALL capture SD_InputData on the cycle the synchronized byte clock rises.
REQ-013 SHALL implement states IDLE, WAIT_SECTOR, FILL, COMMIT and DONE.
REQ-014 IDLE: on Start with SectorCount != 0, SHALL latch the inputs, drive SD_InputAddress = StartAddress, set Busy and go to WAIT_SECTOR; on Start with SectorCount = 0, SHALL go to DONE.
REQ-015 WAIT_SECTOR: on a rising edge of synchronized EnableDataRead, SHALL select the empty bank (bank 0 preferred) and go to FILL; if no bank is empty, SHALL go to FILL in discard mode.
REQ-016 FILL: SHALL write one byte per byte-clock edge at index 0..SECTOR_BYTES-1, and SHALL go to COMMIT after byte SECTOR_BYTES-1.
REQ-017 FILL: if EnableDataRead falls before SECTOR_BYTES bytes arrive, SHALL abandon the sector, keep the bank empty and the address unchanged, and return to WAIT_SECTOR.
REQ-018 COMMIT (one cycle), normal mode: SHALL mark the bank full, add ADDR_STEP to SD_InputAddress modulo 2^24, decrement the remaining count, then go to WAIT_SECTOR, or to DONE if the count reaches 0.
REQ-019 COMMIT, discard mode: SHALL pulse Overrun high for one cycle, leave the address unchanged so the same sector is re-read, and return to WAIT_SECTOR.
REQ-020 SHALL update SD_InputAddress only in IDLE or COMMIT, so the address is stable at every EnableDataRead rise.
REQ-021 Consumer side: RdValid SHALL be high while the current read bank is full; RdReq with RdValid high SHALL pop one byte, and RdData SHALL update on the next cycle (1-cycle latency).
REQ-022 Consumer side: the pop of byte SECTOR_BYTES-1 SHALL free the bank and switch the read bank; reads SHALL alternate bank 0, bank 1 in commit order.
REQ-023 RdReq with RdValid low SHALL pulse Underrun for one cycle and have no other effect.
REQ-024 A same-cycle COMMIT of bank X and free of bank Y SHALL both take effect; on the following cycle, RdValid SHALL reflect the new full bank.
REQ-025 DONE: SHALL clear Busy and hold Done high until the next Start, while remaining full banks stay readable.
REQ-026 Start while Busy SHALL be ignored.

Reset
REQ-027 Reset SHALL clear state to IDLE, both banks to empty, SD_InputAddress, RdData, RdValid, Busy, Done, Overrun and Underrun to 0, and the synchronizers to 0; Reset mid-FILL SHALL drop the partial sector.

Configuration
REQ-028 With SD_SCHED_LOOP_EN defined, reaching count 0 SHALL reload StartAddress and SectorCount and continue in WAIT_SECTOR; DONE is then reached only after Reset.
REQ-029 Without SD_SCHED_LOOP_EN, DONE behaviour SHALL follow REQ-025.

Verification
REQ-030 Start(addr 0x000100, count 2), two 512-byte sectors 0x00..0xFF repeating -> SD_InputAddress 0x000100, 0x000102, 0x000104; 1024 pops return the pattern; Done=1.
REQ-031 Three sectors sent with no RdReq -> third sector discarded, Overrun pulses once, address held at start+4, and bank 0 data intact on pops.
REQ-032 RdReq held high with both banks empty -> Underrun pulses every cycle, RdValid=0.
REQ-033 EnableDataRead drops after 100 bytes -> no commit, address unchanged, and a subsequent full sector commits to bank 0.
REQ-034 Reset asserted at byte 300 of FILL -> all outputs 0 next cycle; a new Start streams correctly.
REQ-035 SD_SCHED_LOOP_EN, count 1, address 0xFFFFFE -> address wraps to 0x000000 then reloads 0xFFFFFE; Done stays 0.

Source files
------------

// File: rtl/sd_sector_scheduler.sv
// Double-banked SD sector streamer: fills two SECTOR_BYTES banks from an async SPI byte stream
// and serves them to a pop consumer. Optional macro SD_SCHED_LOOP_EN replays the range forever.
`timescale 1ns/1ps
module sd_sector_scheduler #(
  parameter int ADDR_STEP    = 2,
  parameter int SECTOR_BYTES = 512
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [23:0] StartAddress,
  input  logic [15:0] SectorCount,
  input  logic [7:0]  SD_InputData,
  input  logic        SD_EnableDataRead,
  input  logic        SD_InputDataClock,
  output logic [23:0] SD_InputAddress,
  input  logic        RdReq,
  output logic [7:0]  RdData,
  output logic        RdValid,
  output logic        Busy,
  output logic        Done,
  output logic        Overrun,
  output logic        Underrun
);

  localparam int              IW       = $clog2(SECTOR_BYTES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(SECTOR_BYTES - 1);
  localparam logic [23:0]     STEP     = 24'(ADDR_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SECTOR,
    S_FILL,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [2:0]    r_bclk_sync;
  logic [2:0]    r_en_sync;
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_discard;
  logic [IW-1:0] r_wr_idx;
  logic          r_rd_bank;
  logic [IW-1:0] r_rd_idx;
  logic [23:0]   r_addr;
  logic [15:0]   r_count;
  logic [7:0]    r_rd_data;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_overrun;
  logic          r_underrun;
`ifdef SD_SCHED_LOOP_EN
  logic [23:0]   r_start_addr;
  logic [15:0]   r_start_count;
  logic          r_reload;
`endif

  logic [7:0]    r_mem [0:(1 << (IW + 1)) - 1];

  logic          w_byte_rise;
  logic          w_en_rise;
  logic          w_en_fall;
  logic          w_pop;
  logic          w_pop_last;
  logic          w_commit;
  logic          w_sel_both_empty;
  logic [1:0]    w_full_nxt;
  logic          w_rd_bank_nxt;

  // Bit [1] is the synchronized level, bit [2] its previous value for edge detection.
  assign w_byte_rise = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_en_rise   = r_en_sync[1]   & ~r_en_sync[2];
  assign w_en_fall   = ~r_en_sync[1]  &  r_en_sync[2];

  assign w_pop            = RdReq & r_valid;
  assign w_pop_last       = w_pop & (r_rd_idx == LAST_IDX);
  assign w_commit         = (r_state == S_COMMIT) & ~r_discard;
  assign w_sel_both_empty = (r_state == S_WAIT_SECTOR) & w_en_rise & (r_full == 2'b00);

  // A commit and a free always target different banks, so both apply in the same cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    w_full_nxt    = r_full;
    w_rd_bank_nxt = r_rd_bank;
    if (w_commit)   w_full_nxt[r_wr_bank] = 1'b1;
    if (w_pop_last) begin
      w_full_nxt[r_rd_bank] = 1'b0;
      w_rd_bank_nxt         = ~r_rd_bank;
    end
    // With both banks empty the next fill goes to bank 0, so the reader must expect bank 0.
    if (w_sel_both_empty) w_rd_bank_nxt = 1'b0;
  end

  // NOTE: sector storage has no reset; the full flags alone say which bytes are meaningful.
  always_ff @(posedge MasterCLK) begin
    if (r_state == S_FILL && !r_discard && w_byte_rise)
      r_mem[{r_wr_bank, r_wr_idx}] <= SD_InputData;
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state     <= S_IDLE;
      r_bclk_sync <= '0;
      r_en_sync   <= '0;
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_discard   <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_idx    <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_underrun  <= 1'b0;
`ifdef SD_SCHED_LOOP_EN
      r_start_addr  <= '0;
      r_start_count <= '0;
      r_reload      <= 1'b0;
`endif
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], SD_InputDataClock};
      r_en_sync   <= {r_en_sync[1:0], SD_EnableDataRead};
      r_full      <= w_full_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_valid     <= w_full_nxt[w_rd_bank_nxt];
      r_underrun  <= RdReq & ~r_valid;
      r_overrun   <= 1'b0;

      if (w_pop) begin
        r_rd_data <= r_mem[{r_rd_bank, r_rd_idx}];
        r_rd_idx  <= w_pop_last ? '0 : r_rd_idx + IW'(1);
      end

      case (r_state)
        S_IDLE, S_DONE: begin
`ifdef SD_SCHED_LOOP_EN
          if (r_reload) begin
            r_reload <= 1'b0;
            r_addr   <= r_start_addr;
            r_count  <= r_start_count;
            r_state  <= S_WAIT_SECTOR;
          end else
`endif
          if (Start) begin
            if (SectorCount != 16'd0) begin
`ifdef SD_SCHED_LOOP_EN
              r_start_addr  <= StartAddress;
              r_start_count <= SectorCount;
`endif
              r_addr  <= StartAddress;
              r_count <= SectorCount;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= S_WAIT_SECTOR;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_WAIT_SECTOR: begin
          if (w_en_rise) begin
            r_wr_idx <= '0;
            r_state  <= S_FILL;
            if (!r_full[0]) begin
              r_wr_bank <= 1'b0;
              r_discard <= 1'b0;
            end else if (!r_full[1]) begin
              r_wr_bank <= 1'b1;
              r_discard <= 1'b0;
            end else begin
              r_discard <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (w_en_fall) begin
            r_state <= S_WAIT_SECTOR;
          end else if (w_byte_rise) begin
            r_wr_idx <= r_wr_idx + IW'(1);
            if (r_wr_idx == LAST_IDX) r_state <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          if (r_discard) begin
            r_overrun <= 1'b1;
            r_state   <= S_WAIT_SECTOR;
          end else begin
            r_addr  <= r_addr + STEP;
            r_count <= r_count - 16'd1;
            if (r_count == 16'd1) begin
`ifdef SD_SCHED_LOOP_EN
              r_reload <= 1'b1;
              r_state  <= S_IDLE;
`else
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
`endif
            end else begin
              r_state <= S_WAIT_SECTOR;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SD_InputAddress = r_addr;
  assign RdData          = r_rd_data;
  assign RdValid         = r_valid;
  assign Busy            = r_busy;
  assign Done            = r_done;
  assign Overrun         = r_overrun;
  assign Underrun        = r_underrun;

endmodule

// File: tb/tb_sd_sector_scheduler.sv
// Directed bench for sd_sector_scheduler; inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_sd_sector_scheduler;

  logic        MasterCLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [23:0] StartAddress = '0;
  logic [15:0] SectorCount = '0;
  logic [7:0]  SD_InputData = '0;
  logic        SD_EnableDataRead = 1'b0;
  logic        SD_InputDataClock = 1'b0;
  logic [23:0] SD_InputAddress;
  logic        RdReq = 1'b0;
  logic [7:0]  RdData;
  logic        RdValid;
  logic        Busy;
  logic        Done;
  logic        Overrun;
  logic        Underrun;

  int n_vec = 0;
  int n_err = 0;
  int ov_cnt = 0;
  int zero_addr_cnt = 0;

  sd_sector_scheduler #(.ADDR_STEP(2), .SECTOR_BYTES(512)) dut (
    .MasterCLK(MasterCLK), .Reset(Reset), .Start(Start),
    .StartAddress(StartAddress), .SectorCount(SectorCount),
    .SD_InputData(SD_InputData), .SD_EnableDataRead(SD_EnableDataRead),
    .SD_InputDataClock(SD_InputDataClock), .SD_InputAddress(SD_InputAddress),
    .RdReq(RdReq), .RdData(RdData), .RdValid(RdValid),
    .Busy(Busy), .Done(Done), .Overrun(Overrun), .Underrun(Underrun)
  );

  always #5 MasterCLK = ~MasterCLK;

  always @(negedge MasterCLK) begin
    if (Overrun === 1'b1) ov_cnt++;
    if (SD_InputAddress === 24'h000000 && Busy === 1'b1) zero_addr_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge MasterCLK);
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; RdReq = 1'b0;
    SD_EnableDataRead = 1'b0; SD_InputDataClock = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic start_cmd(input logic [23:0] addr, input logic [15:0] cnt);
    StartAddress = addr; SectorCount = cnt; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    SD_InputData = b; SD_InputDataClock = 1'b1;
    repeat (3) tick();
    SD_InputDataClock = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_bytes(input int n, input int seed);
    SD_EnableDataRead = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < n; i++) send_byte(8'(seed + i));
  endtask

  task automatic end_sector();
    SD_EnableDataRead = 1'b0;
    repeat (8) tick();
  endtask

  task automatic drain(input int n, input int seed, input string name);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic [7:0] exp_b;
      while (RdValid !== 1'b1 && t < 100) begin tick(); t++; end
      if (t >= 100) begin
        n_vec++; n_err++;
        $display("FAIL %s: RdValid never rose before byte %0d (timeout)", name, i);
        return;
      end
      RdReq = 1'b1;
      tick();
      RdReq = 1'b0;
      exp_b = 8'(seed + i);
      n_vec++;
      if (RdData !== exp_b) begin
        n_err++;
        $display("FAIL %s byte %0d: RdData got %h expected %h", name, i, RdData, exp_b);
      end
    end
  endtask

  task automatic expect_addr(input logic [23:0] exp_a, input string name);
    n_vec++;
    if (SD_InputAddress !== exp_a) begin
      n_err++;
      $display("FAIL %s: SD_InputAddress got %h expected %h", name, SD_InputAddress, exp_a);
    end
  endtask

  task automatic expect_flags(input logic v, input logic b, input logic d, input string name);
    n_vec++;
    if ({RdValid, Busy, Done} !== {v, b, d}) begin
      n_err++;
      $display("FAIL %s: {RdValid,Busy,Done} got %b expected %b", name, {RdValid, Busy, Done}, {v, b, d});
    end
  endtask

  task automatic test_reset();
    do_reset();
    expect_addr(24'h000000, "reset_addr");
    n_vec++;
    if ({RdData, RdValid, Busy, Done, Overrun, Underrun} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", {RdData, RdValid, Busy, Done, Overrun, Underrun});
    end
  endtask

  task automatic test_stream();
    do_reset();
    start_cmd(24'h000100, 16'd2);
    expect_addr(24'h000100, "stream_start_addr");
    expect_flags(1'b0, 1'b1, 1'b0, "stream_start_flags");
    send_bytes(512, 0); end_sector();
    expect_addr(24'h000102, "stream_addr1");
    expect_flags(1'b1, 1'b1, 1'b0, "stream_flags1");
    start_cmd(24'hABCDEF, 16'd5);
    tick();
    expect_addr(24'h000102, "start_while_busy_ignored");
    send_bytes(512, 0); end_sector();
    expect_addr(24'h000104, "stream_addr2");
    expect_flags(1'b1, 1'b0, 1'b1, "stream_done_flags");
    drain(1024, 0, "stream_pop");
    tick();
    expect_flags(1'b0, 1'b0, 1'b1, "stream_drained_flags");
  endtask

  task automatic test_zero_count();
    do_reset();
    start_cmd(24'h000777, 16'd0);
    tick();
    expect_flags(1'b0, 1'b0, 1'b1, "zero_count_flags");
    expect_addr(24'h000000, "zero_count_addr");
  endtask

  task automatic test_overrun();
    int ov_base;
    do_reset();
    start_cmd(24'h000200, 16'd3);
    ov_base = ov_cnt;
    send_bytes(512, 8'h00); end_sector();
    send_bytes(512, 8'h40); end_sector();
    n_vec++;
    if (ov_cnt - ov_base !== 0) begin
      n_err++;
      $display("FAIL overrun_early: pulses got %0d expected 0", ov_cnt - ov_base);
    end
    send_bytes(512, 8'h80); end_sector();
    n_vec++;
    if (ov_cnt - ov_base !== 1) begin
      n_err++;
      $display("FAIL overrun_pulse: pulses got %0d expected 1", ov_cnt - ov_base);
    end
    expect_addr(24'h000204, "overrun_addr_held");
    expect_flags(1'b1, 1'b1, 1'b0, "overrun_flags");
    drain(512, 8'h00, "overrun_bank0");
    drain(512, 8'h40, "overrun_bank1");
    send_bytes(512, 8'h80); end_sector();
    expect_addr(24'h000206, "overrun_reread_addr");
    expect_flags(1'b1, 1'b0, 1'b1, "overrun_reread_flags");
    drain(512, 8'h80, "overrun_reread");
  endtask

  task automatic test_underrun();
    do_reset();
    RdReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({Underrun, RdValid} !== 2'b10) begin
        n_err++;
        $display("FAIL underrun_cycle%0d: {Underrun,RdValid} got %b expected 10", i, {Underrun, RdValid});
      end
    end
    RdReq = 1'b0;
    tick();
    n_vec++;
    if (Underrun !== 1'b0) begin
      n_err++;
      $display("FAIL underrun_release: Underrun got %b expected 0", Underrun);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    start_cmd(24'h000300, 16'd1);
    send_bytes(100, 8'h11); end_sector();
    expect_addr(24'h000300, "abandon_addr_held");
    expect_flags(1'b0, 1'b1, 1'b0, "abandon_flags");
    send_bytes(512, 8'h22); end_sector();
    expect_addr(24'h000302, "abandon_retry_addr");
    expect_flags(1'b1, 1'b0, 1'b1, "abandon_retry_flags");
    drain(4, 8'h22, "abandon_bank0");
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    start_cmd(24'h000400, 16'd2);
    send_bytes(300, 8'h05);
    RdReq = 1'b1;
    tick();
    Reset = 1'b1; SD_EnableDataRead = 1'b0;
    tick();
    expect_addr(24'h000000, "midfill_reset_addr");
    n_vec++;
    if ({RdData, RdValid, Busy, Done, Overrun, Underrun} !== 13'h0) begin
      n_err++;
      $display("FAIL midfill_reset_outputs: got %h expected 0", {RdData, RdValid, Busy, Done, Overrun, Underrun});
    end
    RdReq = 1'b0; Reset = 1'b0;
    repeat (4) tick();
    start_cmd(24'h000500, 16'd1);
    send_bytes(512, 8'h33); end_sector();
    expect_addr(24'h000502, "midfill_restart_addr");
    expect_flags(1'b1, 1'b0, 1'b1, "midfill_restart_flags");
    drain(512, 8'h33, "midfill_restart_pop");
  endtask

`ifdef SD_SCHED_LOOP_EN
  task automatic test_loop();
    int z_base;
    do_reset();
    start_cmd(24'hFFFFFE, 16'd1);
    z_base = zero_addr_cnt;
    send_bytes(512, 8'h55); end_sector();
    n_vec++;
    if (zero_addr_cnt - z_base < 1) begin
      n_err++;
      $display("FAIL loop_wrap: cycles at 0x000000 got %0d expected >=1", zero_addr_cnt - z_base);
    end
    expect_addr(24'hFFFFFE, "loop_reload_addr");
    expect_flags(1'b1, 1'b1, 1'b0, "loop_flags");
    drain(512, 8'h55, "loop_pop");
  endtask
`endif

  initial begin
    test_reset();
    test_underrun();
`ifdef SD_SCHED_LOOP_EN
    test_loop();
`else
    test_stream();
    test_zero_count();
    test_overrun();
    test_abandon();
    test_reset_mid_fill();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
